// File: rtl/axi_dsid_addr_mapper_pkg.sv
// Shared definitions for the DSID address mapper: config FSM encoding,
// identity-table constants and the saturating violation-count helper.
package mapper_pkg;

  typedef logic [1:0] cfg_state_t;

  localparam cfg_state_t CFG_IDLE  = 2'd0;
  localparam cfg_state_t CFG_DRAIN = 2'd1;
  localparam cfg_state_t CFG_APPLY = 2'd2;

  localparam int unsigned MAX_ADDR_WIDTH = 64;
  localparam logic [MAX_ADDR_WIDTH-1:0] IDENT_BASE = '0;
  localparam logic [MAX_ADDR_WIDTH-1:0] IDENT_MASK = '1;

  function automatic logic [31:0] sat_add32(input logic [31:0] cnt, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {31'd0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/axi_dsid_addr_mapper_if.sv
// AXI4 bundle used on both sides of the DSID mapper; user carries the DSID.
interface axi_dsid_addr_mapper_if #(
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned USER_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [ID_WIDTH-1:0]     awid;
  logic [USER_WIDTH-1:0]   awuser;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [ID_WIDTH-1:0]     arid;
  logic [USER_WIDTH-1:0]   aruser;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awid, awuser, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output araddr, arlen, arsize, arburst, arid, aruser, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awaddr, awlen, awsize, awburst, awid, awuser, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input araddr, arlen, arsize, arburst, arid, aruser, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_dsid_addr_mapper_slice.sv
// Two-entry skid buffer: one output register plus one skid register, giving
// one cycle of latency and full throughput while the consumer keeps up.
module axi_addr_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             hold_i,
  input  logic             out_en_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             empty_o
);
  logic             outValid_q;
  logic [WIDTH-1:0] outData_q;
  logic             skidValid_q;
  logic [WIDTH-1:0] skidData_q;
  logic             inFire;
  logic             outFire;

  assign in_ready_o  = !skidValid_q && !hold_i;
  assign inFire      = in_valid_i && in_ready_o;
  assign out_valid_o = outValid_q && out_en_i;
  assign outFire     = out_valid_o && out_ready_i;
  assign out_data_o  = outData_q;
  assign empty_o     = !outValid_q && !skidValid_q;

  // The skid entry only fills while the output register is stalled, so it
  // always refills the output register before any newer beat can.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
    end else if (!outValid_q || outFire) begin
      if (skidValid_q) begin
        outValid_q  <= 1'b1;
        outData_q   <= skidData_q;
        skidValid_q <= 1'b0;
      end else begin
        outValid_q <= inFire;
        if (inFire) outData_q <= in_data_i;
      end
    end else if (inFire) begin
      skidValid_q <= 1'b1;
      skidData_q  <= in_data_i;
    end
  end
endmodule

// File: rtl/axi_dsid_addr_mapper.sv
// Per-DSID AXI address remapper with programmable base/mask table, address
// register slices, outstanding-burst tracking and drain-before-update config.
module axi_dsid_addr_mapper
  import mapper_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DSID_WIDTH = 2,
  parameter int unsigned MAX_OUTST  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi_dsid_addr_mapper_if.slave  s_axi,
  axi_dsid_addr_mapper_if.master m_axi,
  input  logic                  map_en,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DSID_WIDTH-1:0] cfg_idx,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_mask,
  output logic [31:0]           viol_cnt
);
  localparam int unsigned NUM_DSID = 2 ** DSID_WIDTH;
  localparam int unsigned CW       = $clog2(MAX_OUTST + 1);
  localparam int unsigned PW       = ADDR_WIDTH + 13 + ID_WIDTH + DSID_WIDTH;
  localparam logic [CW-1:0] OUTST_LIMIT = CW'(MAX_OUTST);

  logic [ADDR_WIDTH-1:0] base_q [NUM_DSID];
  logic [ADDR_WIDTH-1:0] mask_q [NUM_DSID];
  cfg_state_t            cfgState_q;
  logic [DSID_WIDTH-1:0] shadowIdx_q;
  logic [ADDR_WIDTH-1:0] shadowBase_q, shadowMask_q;
  logic                  live_q;
  logic [CW-1:0]         wrOutst_q, wrOutst_d, rdOutst_q, rdOutst_d;
  logic [31:0]           violCnt_q;

  logic [DSID_WIDTH-1:0] awDsid, arDsid;
  logic [ADDR_WIDTH-1:0] awMapped, arMapped;
  logic                  awViol, arViol, awFire, arFire;
  logic                  acceptHold, awEmpty, arEmpty;
  logic [PW-1:0]         awIn, awOut, arIn, arOut;
  logic                  wrInc, wrDec, rdInc, rdDec;
  logic [1:0]            violInc;
  logic [DATA_WIDTH-1:0] wData, rData;

  assign awDsid   = s_axi.awuser[DSID_WIDTH-1:0];
  assign arDsid   = s_axi.aruser[DSID_WIDTH-1:0];
  assign awMapped = map_en ? (base_q[awDsid] | (s_axi.awaddr & mask_q[awDsid])) : s_axi.awaddr;
  assign arMapped = map_en ? (base_q[arDsid] | (s_axi.araddr & mask_q[arDsid])) : s_axi.araddr;
  assign awViol   = map_en && ((s_axi.awaddr & ~mask_q[awDsid]) != '0);
  assign arViol   = map_en && ((s_axi.araddr & ~mask_q[arDsid]) != '0);
  assign awFire   = s_axi.awvalid && s_axi.awready;
  assign arFire   = s_axi.arvalid && s_axi.arready;
  assign violInc  = {1'b0, awFire && awViol} + {1'b0, arFire && arViol};

  assign acceptHold = !live_q || (cfgState_q != CFG_IDLE);
  assign cfg_ready  = live_q && (cfgState_q == CFG_IDLE);
  assign viol_cnt   = violCnt_q;

  assign awIn = {awMapped, s_axi.awlen, s_axi.awsize, s_axi.awburst, s_axi.awid, s_axi.awuser};
  assign arIn = {arMapped, s_axi.arlen, s_axi.arsize, s_axi.arburst, s_axi.arid, s_axi.aruser};
  assign {m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst, m_axi.awid, m_axi.awuser} = awOut;
  assign {m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst, m_axi.arid, m_axi.aruser} = arOut;

  axi_addr_slice #(.WIDTH(PW)) u_aw_slice (
    .clk(aclk), .rst_n(aresetn),
    .in_valid_i(s_axi.awvalid), .in_ready_o(s_axi.awready), .in_data_i(awIn),
    .hold_i(acceptHold), .out_en_i(wrOutst_q != OUTST_LIMIT),
    .out_valid_o(m_axi.awvalid), .out_ready_i(m_axi.awready), .out_data_o(awOut),
    .empty_o(awEmpty)
  );

  axi_addr_slice #(.WIDTH(PW)) u_ar_slice (
    .clk(aclk), .rst_n(aresetn),
    .in_valid_i(s_axi.arvalid), .in_ready_o(s_axi.arready), .in_data_i(arIn),
    .hold_i(acceptHold), .out_en_i(rdOutst_q != OUTST_LIMIT),
    .out_valid_o(m_axi.arvalid), .out_ready_i(m_axi.arready), .out_data_o(arOut),
    .empty_o(arEmpty)
  );

  assign wData         = s_axi.wdata;
  assign m_axi.wdata   = wData;
  assign m_axi.wstrb   = s_axi.wstrb;
  assign m_axi.wlast   = s_axi.wlast;
  assign m_axi.wvalid  = s_axi.wvalid;
  assign s_axi.wready  = m_axi.wready;
  assign s_axi.bid     = m_axi.bid;
  assign s_axi.bresp   = m_axi.bresp;
  assign s_axi.bvalid  = m_axi.bvalid;
  assign m_axi.bready  = s_axi.bready;
  assign rData         = m_axi.rdata;
  assign s_axi.rdata   = rData;
  assign s_axi.rid     = m_axi.rid;
  assign s_axi.rresp   = m_axi.rresp;
  assign s_axi.rlast   = m_axi.rlast;
  assign s_axi.rvalid  = m_axi.rvalid;
  assign m_axi.rready  = s_axi.rready;

  assign wrInc = m_axi.awvalid && m_axi.awready;
  assign wrDec = m_axi.bvalid && s_axi.bready;
  assign rdInc = m_axi.arvalid && m_axi.arready;
  assign rdDec = m_axi.rvalid && s_axi.rready && m_axi.rlast;

  // A stray response with nothing outstanding must not wrap the counter.
  always_comb begin
    wrOutst_d = wrOutst_q;
    rdOutst_d = rdOutst_q;
    if (wrInc && !wrDec) wrOutst_d = wrOutst_q + CW'(1);
    else if (wrDec && !wrInc && wrOutst_q != '0) wrOutst_d = wrOutst_q - CW'(1);
    if (rdInc && !rdDec) rdOutst_d = rdOutst_q + CW'(1);
    else if (rdDec && !rdInc && rdOutst_q != '0) rdOutst_d = rdOutst_q - CW'(1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live_q    <= 1'b0;
      wrOutst_q <= '0;
      rdOutst_q <= '0;
      violCnt_q <= '0;
    end else begin
      live_q    <= 1'b1;
      wrOutst_q <= wrOutst_d;
      rdOutst_q <= rdOutst_d;
      violCnt_q <= sat_add32(violCnt_q, violInc);
    end
  end

  // Table updates wait until no beat mapped with the old entry is in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cfgState_q   <= CFG_IDLE;
      shadowIdx_q  <= '0;
      shadowBase_q <= '0;
      shadowMask_q <= '0;
      for (int i = 0; i < NUM_DSID; i++) begin
        base_q[i] <= IDENT_BASE[ADDR_WIDTH-1:0];
        mask_q[i] <= IDENT_MASK[ADDR_WIDTH-1:0];
      end
    end else begin
      case (cfgState_q)
        CFG_IDLE: begin
          if (cfg_valid && cfg_ready) begin
            shadowIdx_q  <= cfg_idx;
            shadowBase_q <= cfg_base;
            shadowMask_q <= cfg_mask;
            cfgState_q   <= CFG_DRAIN;
          end
        end
        CFG_DRAIN: begin
          if (awEmpty && arEmpty && wrOutst_q == '0 && rdOutst_q == '0) cfgState_q <= CFG_APPLY;
        end
        CFG_APPLY: begin
          base_q[shadowIdx_q] <= shadowBase_q;
          mask_q[shadowIdx_q] <= shadowMask_q;
          cfgState_q          <= CFG_IDLE;
        end
        default: cfgState_q <= CFG_IDLE;
      endcase
    end
  end
endmodule
